hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the decode stage of the 5-stage RISC-V core. It decides each cycle whether fetch and decode advance, stall, or are squashed. It drives the decode Control unit's Control_on bubble input plus the PC and pipeline-register write enables. Handles load-use stalls, taken-branch/jal flushes with a programmable squash window, and data-memory wait freezes; it also keeps a saturating stall counter.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles decode is bubbled after a taken branch/jal (1..7)
CNT_W, 16, width of stall_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous and active-high
id_inst  input  32  instruction currently in IF/ID (decode stage)
ex_MemRead  input  1  instruction in EX is a load
ex_rd  input  5  destination register of instruction in EX
branch_taken  input  1  EX resolved a taken branch or jal this cycle
mem_busy  input  1  data memory not ready; whole pipeline must hold
pc_write  output  1  PC update enable
if_id_write  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID register clear to NOP (wins over if_id_write)
id_ex_write  output  1  ID/EX register load enable
Control_on  output  1  1 = normal decode controls, 0 = force all controls to 0 (bubble)
stall_count  output  CNT_W  saturating count of cycles with pc_write=0 or Control_on=0

Behaviour:
- States: RUN, FLUSH, MEM_WAIT. Plus flush_cnt (3 bits).
- Reset (rst=1, async): state=RUN, flush_cnt=0, stall_count=0. Outputs forced: pc_write=0, if_id_write=0, id_ex_write=0, if_id_flush=1, Control_on=0. Outputs follow state/inputs combinationally from the first rising edge after rst deasserts.
- Register use decode on id_inst[6:0]:
  - rs1 (bits 19:15) is used unless opcode is 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
  - rs2 (bits 24:20) is used only for 0110011 (R), 0100011 (S) and 1100011 (B).
- load_use = ex_MemRead & ex_rd!=0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
- Priority, evaluated each cycle in any state: mem_busy > branch_taken > FLUSH window > load_use.
- mem_busy=1, any state:
  - pc_write=0, if_id_write=0, id_ex_write=0, if_id_flush=0, Control_on=1.
  - Next state MEM_WAIT; flush_cnt holds.
  - On leaving MEM_WAIT, return to FLUSH if flush_cnt!=0, else RUN.
- branch_taken=1 with mem_busy=0:
  - Same cycle: pc_write=1 (target), if_id_flush=1, id_ex_write=1, Control_on=0.
  - If FLUSH_CYCLES>1: flush_cnt<=FLUSH_CYCLES-1, state<=FLUSH. Otherwise stay RUN.
  - A new branch_taken while in FLUSH reloads flush_cnt.
- FLUSH state, no higher-priority event:
  - pc_write=1, if_id_flush=1, id_ex_write=1, Control_on=0; flush_cnt decrements.
  - When flush_cnt reaches 0, next state RUN.
- RUN with load_use:
  - pc_write=0, if_id_write=0, if_id_flush=0, id_ex_write=1, Control_on=0.
  - Exactly one bubble: the next cycle the load has left EX, so load_use clears.
  - Not evaluated in FLUSH, because the decode instruction is being squashed.
- RUN, no event: all enables 1, if_id_flush=0, Control_on=1.
- stall_count increments on every non-reset cycle where pc_write=0 or Control_on=0, and saturates at all-ones.

Test Plan:
- Reset mid-FLUSH (FLUSH_CYCLES=3): assert rst while flush_cnt=2 -> outputs go to reset values immediately, without waiting for a clock edge; after release the state is RUN, stall_count=0, and enables are 1.
- Load-use: ex_MemRead=1, ex_rd=5, id_inst=add x6,x5,x7 -> exactly one cycle of pc_write=0, if_id_write=0, Control_on=0. Same with ex_rd=0, or with id_inst=lui x5 -> no stall.
- Taken branch, FLUSH_CYCLES=1 then 3: pulse branch_taken for one cycle -> Control_on=0 and if_id_flush=1 for 1 cycle and 3 cycles respectively; stall_count advances by 1 and 3.
- mem_busy held 4 cycles, with load_use and branch_taken also asserted -> all write enables 0 and Control_on=1 for 4 cycles. In the cycle mem_busy drops, the branch flush is applied.
- mem_busy arriving in FLUSH with flush_cnt=1 -> freeze, then one remaining flush cycle, then RUN.
- stall_count saturation (CNT_W=4): 20 stall cycles -> stall_count=15 and holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller for the 5-stage RISC-V pipeline.
// Each cycle it decides whether fetch/decode advance, stall (load-use),
// freeze (data memory busy) or get squashed (taken branch/jal). It also
// keeps a saturating count of cycles in which the PC was held or decode
// was bubbled.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             Control_on,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t           state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  // Low from reset until the first clock edge after release; while low the
  // outputs keep their reset values and no state advances.
  logic             active_q;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used, load_use, in_flush;
  logic       unused_inst_bits;

  assign opcode           = id_inst[6:0];
  assign rs1              = id_inst[19:15];
  assign rs2              = id_inst[24:20];
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

  // Source-register usage decode and load-use detection.
  always_comb begin
    rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    rs2_used = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    load_use = ex_MemRead && (ex_rd != 5'd0) &&
               ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
  end

  // A freeze that interrupted a squash window resumes it directly in the
  // cycle memory becomes ready, so MEM_WAIT with a pending count acts as FLUSH.
  assign in_flush = (state_q == FLUSH) || ((state_q == MEM_WAIT) && (flush_cnt_q != 3'd0));

  // Next-state and output decode, priority mem_busy > branch > squash > load-use.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_write = 1'b1;
    Control_on  = 1'b1;
    if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      state_d     = MEM_WAIT;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      Control_on  = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        flush_cnt_d = FLUSH_RELOAD;
        state_d     = FLUSH;
      end else begin
        flush_cnt_d = 3'd0;
        state_d     = RUN;
      end
    end else if (in_flush) begin
      if_id_flush = 1'b1;
      Control_on  = 1'b0;
      flush_cnt_d = flush_cnt_q - 3'd1;
      state_d     = (flush_cnt_q == 3'd1) ? RUN : FLUSH;
    end else begin
      state_d = RUN;
      if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        Control_on  = 1'b0;
      end
    end
    if (rst || !active_q) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_write = 1'b0;
      Control_on  = 1'b0;
    end
  end

  // Saturating stall counter; only functional cycles are counted.
  always_comb begin
    stall_count_d = stall_count_q;
    if (active_q && (!pc_write || !Control_on) && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      flush_cnt_q   <= 3'd0;
      stall_count_q <= '0;
      active_q      <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (active_q) begin
        state_q       <= state_d;
        flush_cnt_q   <= flush_cnt_d;
        stall_count_q <= stall_count_d;
      end
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share stimulus:
// index 0 has a 1-cycle squash window and a 16-bit counter, index 1 a
// 3-cycle window and a 4-bit counter. Expected outputs come from a
// priority-rule reference model tracking only "squash cycles still owed".
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] id_inst = 32'h0000_0013;
  logic        ex_MemRead = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        branch_taken = 1'b0;
  logic        mem_busy = 1'b0;

  logic [1:0]  pc_w, ifw_w, fl_w, iew_w, co_w;
  logic [15:0] sc0;
  logic [3:0]  sc1;

  int n_checks = 0;
  int n_fail   = 0;

  // model state per instance
  int m_left [2];
  int m_cnt  [2];
  int fc_of  [2] = '{1, 3};
  int cmax   [2] = '{65535, 15};

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADD_657 = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] LUI_X5  = {5'd0, 5'd0, 5'd5, 3'd0, 5'd5, 7'b0110111};
  localparam logic [31:0] SW_X5   = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] ADDI_5  = {12'd5, 5'd2, 3'd0, 5'd1, 7'b0010011};

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_fc1 (
    .clk(clk), .rst(rst), .id_inst(id_inst), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_w[0]), .if_id_write(ifw_w[0]), .if_id_flush(fl_w[0]),
    .id_ex_write(iew_w[0]), .Control_on(co_w[0]), .stall_count(sc0)
  );

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_fc3 (
    .clk(clk), .rst(rst), .id_inst(id_inst), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_w[1]), .if_id_write(ifw_w[1]), .if_id_flush(fl_w[1]),
    .id_ex_write(iew_w[1]), .Control_on(co_w[1]), .stall_count(sc1)
  );

  function automatic logic [4:0] obs_vec(input int k);
    return {pc_w[k], ifw_w[k], fl_w[k], iew_w[k], co_w[k]};
  endfunction

  function automatic int obs_cnt(input int k);
    return (k == 0) ? int'(sc0) : int'(sc1);
  endfunction

  // Does decode read a register the load in EX is about to write?
  function automatic bit model_load_use(input logic [31:0] inst, input bit mr, input logic [4:0] rd);
    logic [6:0] op;
    bit u1, u2;
    op = inst[6:0];
    u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    return mr && (rd != 5'd0) && ((u1 && inst[19:15] == rd) || (u2 && inst[24:20] == rd));
  endfunction

  task automatic check_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      assert (obs_vec(k) === 5'b00100) else begin
        n_fail++;
        $error("FAIL %s ctl[%0d]: got %b want 00100", tag, k, obs_vec(k));
      end
      n_checks++;
      assert (obs_cnt(k) === 0) else begin
        n_fail++;
        $error("FAIL %s cnt[%0d]: got %0d want 0", tag, k, obs_cnt(k));
      end
    end
  endtask

  // Assert reset now (no edge needed), release it between edges, then
  // let the first edge after release pass before functional cycles start.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset({tag, "_during"});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset({tag, "_released"});
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0;
      m_cnt[k]  = 0;
    end
    $display("reset %s done", tag);
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model.
  task automatic step(input string tag, input bit mb, input bit bt, input bit mr,
                      input logic [4:0] rd, input logic [31:0] inst);
    logic [4:0] exp_v [2];
    logic [4:0] mask  [2];
    int         nl    [2];
    bit         lu;
    mem_busy = mb; branch_taken = bt; ex_MemRead = mr; ex_rd = rd; id_inst = inst;
    lu = model_load_use(inst, mr, rd);
    for (int k = 0; k < 2; k++) begin
      mask[k] = 5'b11111;
      if (mb) begin
        exp_v[k] = 5'b00001; nl[k] = m_left[k];
      end else if (bt) begin
        exp_v[k] = 5'b11110; nl[k] = fc_of[k] - 1; mask[k] = 5'b10111;
      end else if (m_left[k] > 0) begin
        exp_v[k] = 5'b11110; nl[k] = m_left[k] - 1; mask[k] = 5'b10111;
      end else if (lu) begin
        exp_v[k] = 5'b00010; nl[k] = 0;
      end else begin
        exp_v[k] = 5'b11011; nl[k] = 0;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      assert ((obs_vec(k) & mask[k]) === (exp_v[k] & mask[k])) else begin
        n_fail++;
        $error("FAIL %s ctl[%0d]: got %b want %b (mask %b)", tag, k, obs_vec(k), exp_v[k], mask[k]);
      end
      n_checks++;
      assert (obs_cnt(k) === m_cnt[k]) else begin
        n_fail++;
        $error("FAIL %s cnt[%0d]: got %0d want %0d", tag, k, obs_cnt(k), m_cnt[k]);
      end
    end
    $display("%s mb=%0b bt=%0b mr=%0b rd=%0d inst=%h ctl0=%b ctl1=%b cnt0=%0d cnt1=%0d",
             tag, mb, bt, mr, rd, inst, obs_vec(0), obs_vec(1), obs_cnt(0), obs_cnt(1));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!exp_v[k][4] || !exp_v[k][0]) m_cnt[k] = (m_cnt[k] >= cmax[k]) ? cmax[k] : m_cnt[k] + 1;
      m_left[k] = nl[k];
    end
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [9];
    logic [31:0] r;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 8)];
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    #1;
    do_reset("init");
    step("idle", 0, 0, 0, 5'd0, NOP);

    // load-use cases
    step("lu_add", 0, 0, 1, 5'd5, ADD_657);
    step("lu_after", 0, 0, 0, 5'd5, ADD_657);
    step("lu_rd0", 0, 0, 1, 5'd0, ADD_657);
    step("lu_lui", 0, 0, 1, 5'd5, LUI_X5);
    step("lu_sw_rs2", 0, 0, 1, 5'd5, SW_X5);
    step("lu_addi_rs2f", 0, 0, 1, 5'd5, ADDI_5);
    step("lu_rs2_add", 0, 0, 1, 5'd7, ADD_657);

    // branch pulse: 1-cycle vs 3-cycle squash
    do_reset("pre_br");
    step("br", 0, 1, 0, 5'd0, NOP);
    for (int i = 0; i < 4; i++) step("br_after", 0, 0, 0, 5'd0, NOP);

    // reset asserted while the 3-cycle window has two cycles left
    step("br2", 0, 1, 0, 5'd0, NOP);
    do_reset("mid_flush");
    step("post_rst", 0, 0, 0, 5'd0, NOP);

    // mem_busy dominates load-use and branch; branch lands when it drops
    for (int i = 0; i < 4; i++) step("mb_all", 1, 1, 1, 5'd5, ADD_657);
    step("mb_drop_br", 0, 1, 0, 5'd0, NOP);
    for (int i = 0; i < 4; i++) step("mb_after", 0, 0, 0, 5'd0, NOP);

    // freeze arriving with one squash cycle still owed (3-cycle instance)
    step("br3", 0, 1, 0, 5'd0, NOP);
    step("fl", 0, 0, 0, 5'd0, NOP);
    for (int i = 0; i < 2; i++) step("fl_mb", 1, 0, 0, 5'd0, NOP);
    for (int i = 0; i < 3; i++) step("fl_resume", 0, 0, 0, 5'd0, NOP);

    // counter saturation on the 4-bit instance
    do_reset("pre_sat");
    for (int i = 0; i < 20; i++) step("sat", 0, 0, 1, 5'd5, ADD_657);
    for (int i = 0; i < 2; i++) step("sat_hold", 0, 0, 0, 5'd0, NOP);

    // randomized traffic
    do_reset("pre_rand");
    for (int i = 0; i < 250; i++) begin
      step("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), rand_inst());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
